// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage of the 16-bit unicycle datapath. It holds the program
//   counter and fetches one instruction word over a req/ack handshake. It
//   latches the word into the instruction register and presents its decoded
//   fields to the ALU stage. It then waits for that stage to commit the
//   next PC.
//
//   Optional feature: define FETCH_WATCHDOG_EN to compile in the fetch
//   watchdog. A FETCH that waits TIMEOUT_CYCLES cycles without an ack
//   enters the FAULT state. With the macro undefined, FETCH waits forever
//   and fetchFault is constant 0.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
//   TIMEOUT_CYCLES  watchdog limit in cycles (1..255), watchdog build only
//
// Ports:
//   clock       in   rising-edge clock
//   resetN      in   asynchronous active-low reset
//   pcIn        in   16  next PC from the ALU stage
//   advance     in   ALU stage consumed the instruction, commit pcIn
//   memAddress  out  16  word address being fetched (the PC register)
//   memReq      out  fetch request
//   memAck      in   memData valid this cycle
//   memData     in   16  instruction word
//   control     out  4   IR[15:12]
//   immediate   out  16  IR[11:0] zero-extended
//   pcOut       out  16  address of the instruction held in IR
//   instrValid  out  IR holds an instruction ready for execution
//   halted      out  HALT instruction fetched
//   fetchFault  out  watchdog expired (0 when compiled out)
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [15:0] pcIn,
  input  logic        advance,
  output logic [15:0] memAddress,
  output logic        memReq,
  input  logic        memAck,
  input  logic [15:0] memData,
  output logic [3:0]  control,
  output logic [15:0] immediate,
  output logic [15:0] pcOut,
  output logic        instrValid,
  output logic        halted,
  output logic        fetchFault
);

  localparam logic [2:0] BOOT   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] HALTED = 3'd3;
  localparam logic [2:0] FAULT  = 3'd4;

  localparam logic [3:0] HALT_OPCODE = 4'hF;

  logic [2:0]  state_r;
  logic [2:0]  stateNext_s;
  logic [15:0] pc_r;
  logic [15:0] pcNext_s;
  logic [15:0] ir_r;
  logic [15:0] irNext_s;

  // Status outputs are kept in their own flops, loaded from the next state.
  // They therefore change on the same edge as the state, and the reset
  // clears them asynchronously.
  logic memReq_r;
  logic instrValid_r;
  logic halted_r;
  logic fetchFault_r;

`ifdef FETCH_WATCHDOG_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wdCount_r;
  logic [7:0] wdCountNext_s;
`else
  // The limit only matters when the watchdog is compiled in.
  logic [7:0] unusedTimeout_s;
  assign unusedTimeout_s = 8'(TIMEOUT_CYCLES);
`endif

  // Next-state, PC, IR and watchdog-counter logic.
  always_comb begin
    stateNext_s = state_r;
    pcNext_s    = pc_r;
    irNext_s    = ir_r;
`ifdef FETCH_WATCHDOG_EN
    wdCountNext_s = wdCount_r;
`endif
    case (state_r)
      BOOT: begin
        stateNext_s = FETCH;
`ifdef FETCH_WATCHDOG_EN
        wdCountNext_s = 8'd0;
`endif
      end
      FETCH: begin
        if (memAck) begin
          // An ack on the limit edge wins over the watchdog.
          irNext_s = memData;
          if (memData[15:12] == HALT_OPCODE) begin
            stateNext_s = HALTED;
          end else begin
            stateNext_s = EXEC;
          end
        end else begin
`ifdef FETCH_WATCHDOG_EN
          wdCountNext_s = wdCount_r + 8'd1;
          if (wdCountNext_s == TIMEOUT_LIMIT) begin
            stateNext_s = FAULT;
          end else begin
            stateNext_s = FETCH;
          end
`else
          stateNext_s = FETCH;
`endif
        end
      end
      EXEC: begin
        if (advance) begin
          pcNext_s    = pcIn;
          stateNext_s = FETCH;
`ifdef FETCH_WATCHDOG_EN
          wdCountNext_s = 8'd0;
`endif
        end else begin
          stateNext_s = EXEC;
        end
      end
      HALTED: begin
        stateNext_s = HALTED;
      end
      FAULT: begin
        stateNext_s = FAULT;
      end
      default: begin
        // Unused encodings restart the fetch sequence cleanly.
        stateNext_s = BOOT;
      end
    endcase
  end

  // State, PC, IR and registered status outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      ir_r         <= 16'h0000;
      memReq_r     <= 1'b0;
      instrValid_r <= 1'b0;
      halted_r     <= 1'b0;
      fetchFault_r <= 1'b0;
    end else begin
      state_r      <= stateNext_s;
      pc_r         <= pcNext_s;
      ir_r         <= irNext_s;
      memReq_r     <= (stateNext_s == FETCH);
      instrValid_r <= (stateNext_s == EXEC);
      halted_r     <= (stateNext_s == HALTED);
`ifdef FETCH_WATCHDOG_EN
      fetchFault_r <= (stateNext_s == FAULT);
`else
      fetchFault_r <= 1'b0;
`endif
    end
  end

`ifdef FETCH_WATCHDOG_EN
  // Watchdog counter: counts FETCH cycles without an ack.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wdCount_r <= 8'd0;
    end else begin
      wdCount_r <= wdCountNext_s;
    end
  end
`endif

  assign memAddress = pc_r;
  assign pcOut      = pc_r;
  assign control    = ir_r[15:12];
  assign immediate  = {4'h0, ir_r[11:0]};
  assign memReq     = memReq_r;
  assign instrValid = instrValid_r;
  assign halted     = halted_r;
`ifdef FETCH_WATCHDOG_EN
  assign fetchFault = fetchFault_r;
`else
  assign fetchFault = 1'b0;
  logic unusedFault_s;
  assign unusedFault_s = fetchFault_r;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch: directed scenarios followed
//   by randomized traffic. All outputs are compared each cycle against a
//   transaction-level reference model kept inside the bench.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [15:0] TB_RESET_PC = 16'h0000;
  localparam int          TB_TIMEOUT  = 4;

  logic        clock;
  logic        resetN;
  logic [15:0] pcIn;
  logic        advance;
  logic [15:0] memAddress;
  logic        memReq;
  logic        memAck;
  logic [15:0] memData;
  logic [3:0]  control;
  logic [15:0] immediate;
  logic [15:0] pcOut;
  logic        instrValid;
  logic        halted;
  logic        fetchFault;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: what the fetch stage is currently doing.
  logic [15:0] mPc;
  logic [15:0] mIr;
  bit          mBoot;
  bit          mFetch;
  bit          mExec;
  bit          mHalt;
  bit          mFault;
  int          mWait;

  instruction_fetch #(
    .RESET_PC(TB_RESET_PC),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .pcIn(pcIn),
    .advance(advance),
    .memAddress(memAddress),
    .memReq(memReq),
    .memAck(memAck),
    .memData(memData),
    .control(control),
    .immediate(immediate),
    .pcOut(pcOut),
    .instrValid(instrValid),
    .halted(halted),
    .fetchFault(fetchFault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic modelReset();
    mPc    = TB_RESET_PC;
    mIr    = 16'h0000;
    mBoot  = 1'b1;
    mFetch = 1'b0;
    mExec  = 1'b0;
    mHalt  = 1'b0;
    mFault = 1'b0;
    mWait  = 0;
  endtask

  // One rising edge of the model, using the inputs the DUT just sampled.
  task automatic modelEdge();
    if (mBoot) begin
      mBoot  = 1'b0;
      mFetch = 1'b1;
      mWait  = 0;
    end else if (mFetch) begin
      if (memAck) begin
        mIr    = memData;
        mFetch = 1'b0;
        if ((memData >> 12) == 16'd15) mHalt = 1'b1;
        else mExec = 1'b1;
      end else begin
`ifdef FETCH_WATCHDOG_EN
        mWait = mWait + 1;
        if (mWait == TB_TIMEOUT) begin
          mFetch = 1'b0;
          mFault = 1'b1;
        end
`endif
      end
    end else if (mExec && advance) begin
      mPc    = pcIn;
      mExec  = 1'b0;
      mFetch = 1'b1;
      mWait  = 0;
    end
  endtask

  task automatic checkOutputs(input string tag);
    checkValue({tag, "_memReq"},     {15'd0, memReq},     {15'd0, mFetch});
    checkValue({tag, "_instrValid"}, {15'd0, instrValid}, {15'd0, mExec});
    checkValue({tag, "_halted"},     {15'd0, halted},     {15'd0, mHalt});
    checkValue({tag, "_fetchFault"}, {15'd0, fetchFault}, {15'd0, mFault});
    checkValue({tag, "_control"},    {12'd0, control},    mIr / 16'd4096);
    checkValue({tag, "_immediate"},  immediate,           mIr % 16'd4096);
    checkValue({tag, "_pcOut"},      pcOut,               mPc);
    checkValue({tag, "_memAddress"}, memAddress,          mPc);
  endtask

  // Called at a falling edge: apply inputs, clock once, check at next fall.
  task automatic step(input string tag, input logic ack, input logic [15:0] data,
                      input logic adv, input logic [15:0] nextPc);
    memAck  = ack;
    memData = data;
    advance = adv;
    pcIn    = nextPc;
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkOutputs(tag);
  endtask

  // Called at a falling edge: asynchronous reset between clock edges.
  task automatic doReset(input string tag);
    #2;
    resetN = 1'b0;
    #1;
    modelReset();
    checkOutputs(tag);
    @(negedge clock);
    checkOutputs({tag, "_held"});
    resetN = 1'b1;
  endtask

  initial begin
    int idle;
    logic [15:0] rdata;
    resetN  = 1'b0;
    memAck  = 1'b0;
    memData = 16'h0000;
    advance = 1'b0;
    pcIn    = 16'h0000;
    modelReset();
    repeat (2) @(negedge clock);
    checkOutputs("por");
    resetN = 1'b1;

    // Basic fetch/execute: ack in the first FETCH cycle.
    step("boot", 1'b1, 16'h5555, 1'b1, 16'h7777);
    checkValue("tp1_reqRise", {15'd0, memReq}, 16'd1);
    step("fetch1", 1'b1, 16'h1234, 1'b0, 16'h0000);
    checkValue("tp1_control", {12'd0, control}, 16'h0001);
    checkValue("tp1_imm", immediate, 16'h0234);
    checkValue("tp1_pcOut", pcOut, 16'h0000);
    step("adv1", 1'b0, 16'h0000, 1'b1, 16'h0001);
    checkValue("tp1_nextAddr", memAddress, 16'h0001);

    // Ack delayed by three cycles.
    for (int i = 0; i < 3; i++) begin
      step("delay", 1'b0, 16'hDEAD, 1'b1, 16'h4444);
      checkValue("tp2_addrHold", memAddress, 16'h0001);
      checkValue("tp2_notValid", {15'd0, instrValid}, 16'd0);
    end
    step("ackLate", 1'b1, 16'h2ABC, 1'b0, 16'h0000);

    // EXEC hold with noisy inputs.
    for (int i = 0; i < 5; i++) begin
      step("hold", i[0], 16'($urandom), 1'b0, 16'($urandom));
      checkValue("tp3_control", {12'd0, control}, 16'h0002);
      checkValue("tp3_pc", pcOut, 16'h0001);
      checkValue("tp3_req", {15'd0, memReq}, 16'd0);
    end
    step("advFFFF", 1'b0, 16'h0000, 1'b1, 16'hFFFF);
    checkValue("tp3_addrFFFF", memAddress, 16'hFFFF);

    // HALT is sticky until reset.
    step("halt", 1'b1, 16'hF000, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step("halted", 1'b1, 16'h1111, 1'b1, 16'h2222);
      checkValue("tp4_halted", {15'd0, halted}, 16'd1);
    end
    doReset("haltReset");

    // Watchdog expiry, then ack on the limit cycle.
    step("wdBoot", 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < TB_TIMEOUT; i++) step("wdWait", 1'b0, 16'h0000, 1'b0, 16'h0000);
`ifdef FETCH_WATCHDOG_EN
    checkValue("tp5_fault", {15'd0, fetchFault}, 16'd1);
    checkValue("tp5_req", {15'd0, memReq}, 16'd0);
`endif
    doReset("wdReset");
    step("wdBoot2", 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < TB_TIMEOUT - 1; i++) step("wdWait2", 1'b0, 16'h0000, 1'b0, 16'h0000);
    step("wdAck", 1'b1, 16'h3001, 1'b0, 16'h0000);
    checkValue("tp5_noFault", {15'd0, fetchFault}, 16'd0);
    checkValue("tp5_exec", {15'd0, instrValid}, 16'd1);

    // Reset asserted in the middle of a fetch.
    step("midAdv", 1'b0, 16'h0000, 1'b1, 16'h0100);
    checkValue("tp6_fetching", {15'd0, memReq}, 16'd1);
    doReset("midFetch");

    // Randomized traffic.
    idle = 0;
    for (int n = 0; n < 3000; n++) begin
      rdata = 16'($urandom);
      if (rdata[15:12] == 4'hF && $urandom_range(0, 3) != 0) rdata[15:12] = 4'hE;
      step("rand", ($urandom_range(0, 2) == 0), rdata, 1'($urandom_range(0, 1)), 16'($urandom));
      if (mHalt || mFault) idle++;
      if (idle > 3 || $urandom_range(0, 199) == 0) begin
        idle = 0;
        doReset("randReset");
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
